// File: rtl/prog_counter_pkg.sv
// prog_counter shared types.
// Mode encodings and one-shot FSM states.
package prog_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/prog_counter_ctrl.sv
// One-shot sequencer for prog_counter.
// Produces busy and the count-hold qualifier.
module prog_counter_ctrl
  import prog_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic oneshot,
  input  logic load,
  input  logic term,
  output logic busy,
  output logic hold
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!oneshot) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (load) state_nxt = RUN;
        RUN: begin
          if (load)      state_nxt = RUN;
          else if (term) state_nxt = DONE;
        end
        DONE:    if (load) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  // outside RUN a one-shot counter ignores en
  assign hold = oneshot && (state != RUN);

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter/timer with
// wrap, saturate and one-shot modes.
module prog_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  import prog_counter_pkg::*;

  logic             oneshot;
  logic             stop;
  logic             hold;
  logic             act;
  logic             at_end;
  logic             term;
  logic [WIDTH-1:0] count_nxt;

  assign oneshot = (mode == MODE_ONESHOT);
  assign stop    = oneshot || (mode == MODE_SAT);
  assign act     = en && !load && !hold;
  // >= so a runtime-lowered max_val still ends the count
  assign at_end  = up_dn ? (count >= max_val)
                         : (count == '0);
  assign term    = act && at_end;

  prog_counter_ctrl u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .oneshot (oneshot),
    .load    (load),
    .term    (term),
    .busy    (busy),
    .hold    (hold)
  );

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      load: count_nxt = load_val;
      term: begin
        if (!stop)
          count_nxt = up_dn ? '0 : max_val;
      end
      (act && !at_end): begin
        count_nxt = up_dn ? count + WIDTH'(1)
                          : count - WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= term;
      if (term)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed vector table,
// async reset sequence, random run vs reference model.
module tb_prog_counter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] max_val;
  logic [1:0]   mode;
  logic         clr_ovf;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;
  logic         busy;

  int n_cmp;
  int n_err;

  prog_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .mode     (mode),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit       up;
    bit       ld;
    bit [3:0] lv;
    bit [3:0] mv;
    bit [1:0] md;
    bit       clr;
    int       ec;
    bit       etc;
    bit       eovf;
    bit       ebusy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    bit e, bit u, bit l, int lv, int mv, int md,
    bit c, int ec, bit etc, bit eovf, bit eb);
    vec_t v;
    v.en = e; v.up = u; v.ld = l;
    v.lv = 4'(lv); v.mv = 4'(mv); v.md = 2'(md);
    v.clr = c; v.ec = ec; v.etc = etc;
    v.eovf = eovf; v.ebusy = eb;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic drive(bit e, bit u, bit l, int lv,
                       int mv, int md, bit c);
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = W'(lv);
    max_val  = W'(mv);
    mode     = 2'(md);
    clr_ovf  = c;
  endtask

  task automatic step(bit e, bit u, bit l, int lv,
                      int mv, int md, bit c);
    drive(e, u, l, lv, mv, md, c);
    @(posedge clk);
    #1;
  endtask

  // reference model state
  int m_cnt;
  bit m_run;
  bit m_tc;
  bit m_ovf;

  task automatic model(bit e, bit u, bit l, int lv,
                       int mv, int md, bit c);
    bit os;
    bit act;
    bit term;
    os   = (md == 2);
    act  = e && !l && !(os && !m_run);
    term = act && (u ? (m_cnt >= mv) : (m_cnt == 0));
    if (l) begin
      m_cnt = lv;
      if (os) m_run = 1'b1;
    end else if (term) begin
      if (md == 0 || md == 3) m_cnt = u ? 0 : mv;
      if (os) m_run = 1'b0;
    end else if (act) begin
      m_cnt = u ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
    end
    if (!os) m_run = 1'b0;
    m_tc = term;
    if (term)   m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(0, 1, 0, 0, 15, 0, 0);

    // wrap up full range
    for (int i = 1; i <= 16; i++)
      vq.push_back(mk(1, 1, 0, 0, 15, 0, 0,
                      i % 16, i == 16, i == 16, 0));
    // down wrap to max_val, then clear ovf
    vq.push_back(mk(0, 0, 1, 2, 5, 0, 0, 2, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 5, 0, 0, 1, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 5, 0, 0, 5, 1, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 5, 0, 0, 4, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 5, 0, 1, 4, 0, 0, 0));
    // saturate
    vq.push_back(mk(0, 1, 1, 7, 9, 1, 0, 7, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 9, 1, 0, 8, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 9, 1, 0, 9, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 9, 1, 0, 9, 1, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 9, 1, 0, 9, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 9, 1, 0, 9, 0, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 9, 1, 1, 9, 0, 0, 0));
    // one-shot
    vq.push_back(mk(0, 1, 1, 3, 6, 2, 0, 3, 0, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 6, 2, 0, 4, 0, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 6, 2, 0, 5, 0, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 6, 2, 0, 6, 0, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 6, 2, 0, 6, 1, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 6, 2, 0, 6, 0, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 6, 2, 0, 6, 0, 1, 0));
    vq.push_back(mk(0, 1, 1, 0, 6, 2, 0, 0, 0, 1, 1));
    vq.push_back(mk(1, 1, 0, 0, 6, 2, 0, 1, 0, 1, 1));
    // lowered max_val, load vs terminal, set-vs-clear
    vq.push_back(mk(0, 1, 1, 10, 15, 0, 1, 10, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 4, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(1, 1, 1, 9, 0, 0, 0, 9, 0, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1, 7, 0, 0, 0, 7, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 12, 5, 0, 0, 12, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 5, 0, 0, 0, 1, 1, 0));
    // reserved mode acts as wrap
    vq.push_back(mk(1, 0, 0, 0, 3, 3, 0, 3, 1, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 3, 3, 0, 2, 0, 1, 0));

    #11;
    rst = 1'b0;
    #1;
    chk("reset.count", int'(count), 0);
    chk("reset.tc", int'(tc), 0);
    chk("reset.ovf", int'(ovf), 0);
    chk("reset.busy", int'(busy), 0);

    foreach (vq[i]) begin
      step(vq[i].en, vq[i].up, vq[i].ld, vq[i].lv,
           vq[i].mv, vq[i].md, vq[i].clr);
      chk($sformatf("vec%0d.count", i), int'(count), vq[i].ec);
      chk($sformatf("vec%0d.tc", i), int'(tc), int'(vq[i].etc));
      chk($sformatf("vec%0d.ovf", i), int'(ovf), int'(vq[i].eovf));
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(vq[i].ebusy));
    end

    // async reset in the middle of a one-shot run
    step(0, 1, 1, 15, 15, 0, 0);
    step(1, 1, 0, 0, 15, 0, 0);
    step(0, 1, 1, 2, 14, 2, 0);
    step(1, 1, 0, 0, 14, 2, 0);
    step(1, 1, 0, 0, 14, 2, 0);
    chk("pre_rst.count", int'(count), 4);
    chk("pre_rst.busy", int'(busy), 1);
    chk("pre_rst.ovf", int'(ovf), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.count", int'(count), 0);
    chk("async_rst.tc", int'(tc), 0);
    chk("async_rst.ovf", int'(ovf), 0);
    chk("async_rst.busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 0, 0, 14, 2, 0);
    chk("post_rst_idle.count", int'(count), 0);
    chk("post_rst_idle.busy", int'(busy), 0);

    // random run against the reference model
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_cnt = 0; m_run = 0; m_tc = 0; m_ovf = 0;
    begin
      bit e, u, l, c;
      int lv, mv, md;
      mv = 9;
      md = 2;
      for (int k = 0; k < 1500; k++) begin
        e  = ($urandom_range(0, 99) < 85);
        u  = $urandom_range(0, 1) != 0;
        l  = ($urandom_range(0, 99) < 8);
        c  = ($urandom_range(0, 99) < 10);
        lv = $urandom_range(0, M - 1);
        if ($urandom_range(0, 99) < 5)
          mv = $urandom_range(0, M - 1);
        if ($urandom_range(0, 99) < 3)
          md = $urandom_range(0, 3);
        step(e, u, l, lv, mv, md, c);
        model(e, u, l, lv, mv, md, c);
        chk($sformatf("rnd%0d.count", k), int'(count), m_cnt);
        chk($sformatf("rnd%0d.tc", k), int'(tc), int'(m_tc));
        chk($sformatf("rnd%0d.ovf", k), int'(ovf), int'(m_ovf));
        chk($sformatf("rnd%0d.busy", k), int'(busy), int'(m_run));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised programmable up/down counter/timer, the next generation of the team's fixed 4-bit free-running counter. Adds configurable width, runtime modulus, direction, synchronous load, enable, wrap/saturate/one-shot modes, a terminal-count pulse and a sticky overflow flag. Used as the standard count/timeout primitive in the test designs and as a stimulus source for the trace tooling.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable
- up_dn  in  1  direction: 1 = up, 0 = down
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value loaded by load
- max_val  in  WIDTH  runtime modulus limit (terminal value for up, reload value for down)
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
- clr_ovf  in  1  clears ovf
- count  out  WIDTH  current count
- tc  out  1  one-cycle terminal-count pulse
- ovf  out  1  sticky overflow/underflow flag
- busy  out  1  one-shot in progress

## Operation
- Reset (async, any time incl. mid-run): count=0, tc=0, ovf=0, busy=0, FSM=IDLE.
- Priority per edge: rst > load > en. load ignores en; a load edge never generates a terminal event.
- Terminal event: en && !load && (up_dn ? count >= max_val : count == 0).
- Non-terminal en edge: count ±1 modulo 2^WIDTH.
- Terminal event, wrap: up → count=0; down → count=max_val.
- Terminal event, saturate: count holds (max_val-side or 0); event recurs every enabled edge.
- Every terminal event, all modes: tc=1 for the following cycle; ovf set.
- ovf: set on terminal event; cleared by clr_ovf; simultaneous set and clear → set wins.
- count > max_val (max_val lowered at runtime) while up: next enabled edge is terminal.
- load_val > max_val: loaded unchanged.
- One-shot FSM (mode 10 only):
  - IDLE: load → RUN (count=load_val).
  - RUN: counts while en; terminal event → DONE, count holds at terminal value (no wrap).
  - DONE: en ignored, count holds; load → RUN.
  - busy = (state == RUN).
- mode ≠ 10: FSM forced to IDLE next edge; busy=0; counting follows the new mode from that edge.

## Timing
- All outputs registered; single-edge latency from inputs to count/tc/ovf/busy.
- tc high in the same cycle count shows the post-terminal value; low otherwise.
- Back-to-back terminal events (saturate, or max_val=0 wrap-up) → tc held high continuously.
- load and terminal condition on the same edge → load wins, no tc, ovf unchanged.
- No combinational input→output paths.

## Structure
- Package prog_counter_pkg: mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and FSM state type/encoding (IDLE, RUN, DONE).
- One sub-module: prog_counter_ctrl — one-shot FSM producing busy and a count-hold qualifier; datapath, tc and ovf in prog_counter.

## Test plan
- WIDTH=4, max_val=15, mode=00, up, en=1, rst high 11 time units then low → count 0,1,…,15,0; tc high exactly when count returns to 0; ovf=1 afterwards.
- max_val=5, down, load_val=2 loaded, mode=00 → 2,1,0,5,4; tc coincident with count=5; clr_ovf pulse with no event → ovf=0.
- mode=01, up, max_val=9, load 7 → 8,9,9,9; tc high from the first held 9 onward; de-assert en → tc=0, count=9.
- mode=10, load_val=3, up, max_val=6 → busy=1, 4,5,6 then DONE: count=6, busy=0, one tc pulse; further en no change; load 0 → busy=1 again.
- Lower max_val from 15 to 4 while count=10 (mode 00, up) → next edge count=0, tc=1; load and terminal on same edge → count=load_val, tc=0.
- Assert rst asynchronously mid-run in one-shot RUN → count, tc, ovf, busy drop to 0 without a clock edge; FSM IDLE.
